// File: rtl/bram_pkg.sv
// Shared BRAM definitions: arbiter FSM states, primitive width modes and the
// registered BRAM command bundle driven by the port arbiter.
package bram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  // Aspect-ratio mode codes of the 18/36 Kb primitive.
  localparam logic [2:0] MODE_W1  = 3'd0;
  localparam logic [2:0] MODE_W2  = 3'd1;
  localparam logic [2:0] MODE_W4  = 3'd2;
  localparam logic [2:0] MODE_W9  = 3'd3;
  localparam logic [2:0] MODE_W18 = 3'd4;
  localparam logic [2:0] MODE_W36 = 3'd5;

  localparam int BRAM_ADDR_W = 15;
  localparam int BRAM_DATA_W = 18;

  function automatic logic [2:0] width_to_mode(input int w);
    if (w <= 1)       return MODE_W1;
    else if (w <= 2)  return MODE_W2;
    else if (w <= 4)  return MODE_W4;
    else if (w <= 9)  return MODE_W9;
    else if (w <= 18) return MODE_W18;
    else              return MODE_W36;
  endfunction

  typedef struct packed {
    logic                   ren;
    logic                   wen;
    logic [1:0]             be;
    logic [BRAM_ADDR_W-1:0] addr;
    logic [BRAM_DATA_W-1:0] wdata;
  } bram_cmd_t;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, priority flips to the
// other requester after every grant.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
        default: gnt_o = 2'b00;
      endcase
    end
    ptr_d = ptr_q;
    if (|gnt_o) ptr_d = gnt_o[0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= 1'b0;
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one BRAM port between two requesters with round-robin arbitration,
// registered commands, read-return tracking and an optional zero-fill after reset.
module bram_port_arbiter
  import bram_pkg::*;
#(
  parameter int ADDR_W         = 14,
  parameter int DATA_W         = 18,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b0
) (
  input  logic              CLK_i,
  input  logic              RESET_ni,
  input  logic [1:0]        REQ_i,
  input  logic [1:0]        WE_i,
  input  logic [1:0]        BE0_i,
  input  logic [1:0]        BE1_i,
  input  logic [ADDR_W-1:0] ADDR0_i,
  input  logic [ADDR_W-1:0] ADDR1_i,
  input  logic [DATA_W-1:0] WDATA0_i,
  input  logic [DATA_W-1:0] WDATA1_i,
  output logic [1:0]        GNT_o,
  output logic [1:0]        RVALID_o,
  output logic [DATA_W-1:0] RDATA_o,
  output logic              BUSY_o,
  output logic              REN_o,
  output logic              WEN_o,
  output logic [1:0]        BE_o,
  output logic [14:0]       ADDR_o,
  output logic [17:0]       WDATA_o,
  input  logic [17:0]       RDATA_i
);

  localparam arb_state_e       ST_INIT  = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  arb_state_e           state_q, state_d;
  logic [ADDR_W-1:0]    clr_addr_q, clr_addr_d;
  bram_cmd_t            cmd_q, cmd_d;
  logic                 rid_q, rid_d;
  logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [RD_LATENCY-1:0] id_pipe_q, id_pipe_d;

  logic [1:0]        gnt;
  logic              run;
  logic              sel;
  logic              req_we;
  logic [1:0]        req_be;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              unused_rdata;

  assign run = (state_q == ST_RUN);

  rr_arb2 u_arb (
    .clk_i  (CLK_i),
    .rst_ni (RESET_ni),
    .en_i   (run),
    .req_i  (REQ_i),
    .gnt_o  (gnt)
  );

  assign sel       = gnt[1];
  assign req_we    = sel ? WE_i[1]  : WE_i[0];
  assign req_be    = sel ? BE1_i    : BE0_i;
  assign req_addr  = sel ? ADDR1_i  : ADDR0_i;
  assign req_wdata = sel ? WDATA1_i : WDATA0_i;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    rid_d      = rid_q;
    cmd_d      = cmd_q;
    cmd_d.ren  = 1'b0;
    cmd_d.wen  = 1'b0;
    cmd_d.be   = 2'b00;
    case (state_q)
      ST_CLEAR: begin
        cmd_d.wen   = 1'b1;
        cmd_d.be    = 2'b11;
        cmd_d.addr  = 15'({16'b0, clr_addr_q} << 1);
        cmd_d.wdata = '0;
        clr_addr_d  = clr_addr_q + 1'b1;
        if (clr_addr_q == CLR_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (|gnt) begin
          cmd_d.addr = 15'({16'b0, req_addr} << 1);
          rid_d      = sel;
          if (req_we) begin
            cmd_d.wen   = 1'b1;
            cmd_d.be    = req_be;
            cmd_d.wdata = 18'(req_wdata);
          end else begin
            cmd_d.ren = 1'b1;
          end
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Read tracker: stage 0 lines up with REN on the BRAM pins.
    vld_pipe_d[0] = cmd_q.ren;
    id_pipe_d[0]  = rid_q;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      id_pipe_d[i]  = id_pipe_q[i-1];
    end
  end

  always_ff @(posedge CLK_i or negedge RESET_ni) begin
    if (!RESET_ni) begin
      state_q    <= ST_INIT;
      clr_addr_q <= '0;
      cmd_q      <= '0;
      rid_q      <= 1'b0;
      vld_pipe_q <= '0;
      id_pipe_q  <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      cmd_q      <= cmd_d;
      rid_q      <= rid_d;
      vld_pipe_q <= vld_pipe_d;
      id_pipe_q  <= id_pipe_d;
    end
  end

  assign GNT_o    = gnt;
  assign BUSY_o   = (state_q == ST_CLEAR);
  assign REN_o    = cmd_q.ren;
  assign WEN_o    = cmd_q.wen;
  assign BE_o     = cmd_q.be;
  assign ADDR_o   = cmd_q.addr;
  assign WDATA_o  = cmd_q.wdata;
  assign RVALID_o = {vld_pipe_q[RD_LATENCY-1] &  id_pipe_q[RD_LATENCY-1],
                     vld_pipe_q[RD_LATENCY-1] & ~id_pipe_q[RD_LATENCY-1]};
  assign RDATA_o  = RDATA_i[DATA_W-1:0];
  assign unused_rdata = ^RDATA_i;

endmodule
